// File: rtl/ps2_rx_pkg.sv
// Shared definitions for the PS/2 receive path and the downstream break-code flag stage.
// Holds the FSM encoding, frame constants and the parity helper.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DPS  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

  // True when {parity, data} carries an odd number of ones.
  function automatic logic parity_is_odd(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_rx_filter.sv
// PS/2 pin conditioning: 2-FF synchronisers, ps2c glitch filter and a one-cycle
// fall_edge strobe on the filtered clock.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_rx,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall_edge,
  output logic ps2d_s
);

  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] filt_sh;
  logic                  filt_clk;
  logic                  filt_next;

  // Filtered clock only moves once the whole window agrees; otherwise it holds.
  always_comb begin
    filt_next = filt_clk;
    if (&filt_sh) begin
      filt_next = 1'b1;
    end else if (~|filt_sh) begin
      filt_next = 1'b0;
    end else begin
      filt_next = filt_clk;
    end
  end

  // Synchronisers, filter window, filtered clock and edge strobe registers.
  always_ff @(posedge clk_rx or posedge reset) begin
    if (reset) begin
      c_sync    <= 2'b11;
      d_sync    <= 2'b11;
      filt_sh   <= {FILTER_LEN{1'b1}};
      filt_clk  <= 1'b1;
      fall_edge <= 1'b0;
    end else begin
      c_sync    <= {c_sync[0], ps2c};
      d_sync    <= {d_sync[0], ps2d};
      filt_sh   <= {c_sync[1], filt_sh[FILTER_LEN-1:1]};
      filt_clk  <= filt_next;
      fall_edge <= filt_clk & ~filt_next;
    end
  end

  assign ps2d_s = d_sync[1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: deserialises start/8 data/odd parity/stop
// and reports each frame as exactly one of rx_done_tick, parity_err or frame_err.
module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic       clk_rx,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

  logic            fall_edge;
  logic            ps2d_s;
  state_t          state, state_next;
  logic [9:0]      b_reg, b_next;
  logic [3:0]      n_reg, n_next;
  logic [TO_W-1:0] to_cnt, to_next;
  logic [7:0]      dout_next;
  logic            done_next, perr_next, ferr_next;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk_rx   (clk_rx),
    .reset    (reset),
    .ps2c     (ps2c),
    .ps2d     (ps2d),
    .fall_edge(fall_edge),
    .ps2d_s   (ps2d_s)
  );

  // State, datapath and registered output pulses.
  always_ff @(posedge clk_rx or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      b_reg        <= 10'd0;
      n_reg        <= 4'd0;
      to_cnt       <= {TO_W{1'b0}};
      dout         <= 8'h00;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_next;
      b_reg        <= b_next;
      n_reg        <= n_next;
      to_cnt       <= to_next;
      dout         <= dout_next;
      rx_done_tick <= done_next;
      parity_err   <= perr_next;
      frame_err    <= ferr_next;
    end
  end

  // Next-state logic; rx_en gates only the start of a frame.
  always_comb begin
    state_next = state;
    b_next     = b_reg;
    n_next     = n_reg;
    to_next    = to_cnt;
    dout_next  = dout;
    done_next  = 1'b0;
    perr_next  = 1'b0;
    ferr_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        to_next = {TO_W{1'b0}};
        if (fall_edge && rx_en && !ps2d_s) begin
          state_next = ST_DPS;
          n_next     = 4'd9;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DPS: begin
        if (fall_edge) begin
          b_next  = {ps2d_s, b_reg[9:1]};
          to_next = {TO_W{1'b0}};
          if (n_reg == 4'd0) begin
            state_next = ST_LOAD;
          end else begin
            n_next = n_reg - 4'd1;
          end
        end else if (to_cnt == TO_LIMIT) begin
          state_next = ST_IDLE;
          ferr_next  = 1'b1;
        end else begin
          to_next = to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      ST_LOAD: begin
        // b_reg = {stop, parity, d7..d0}; stop error outranks parity error.
        if (!b_reg[9]) begin
          ferr_next = 1'b1;
        end else if (!parity_is_odd(b_reg[8:0])) begin
          perr_next = 1'b1;
        end else begin
          dout_next = b_reg[7:0];
          done_next = 1'b1;
        end
        state_next = ST_IDLE;
        n_next     = 4'd0;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed self-checking bench for ps2_rx: good frames, back-to-back, parity/stop
// errors, inter-edge timeout, glitches, rx_en gating and mid-frame reset.
module tb_ps2_rx;

  localparam int TO_CYC = 2000;

  logic       clk;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;

  int checks;
  int passes;
  int cnt_done;
  int cnt_perr;
  int cnt_ferr;
  int pulse_viol;
  logic [7:0] rx_q[$];
  logic prev_any;

  ps2_rx #(
    .FILTER_LEN (8),
    .TIMEOUT_CYC(TO_CYC),
    .TO_W       (16)
  ) dut (
    .clk_rx      (clk),
    .reset       (reset),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .rx_en       (rx_en),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .parity_err  (parity_err),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Output monitor sampled on the inactive edge.
  initial begin
    cnt_done = 0; cnt_perr = 0; cnt_ferr = 0; pulse_viol = 0; prev_any = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_done_tick) begin
        cnt_done++;
        rx_q.push_back(dout);
      end
      if (parity_err) cnt_perr++;
      if (frame_err) cnt_ferr++;
      if (prev_any && (rx_done_tick || parity_err || frame_err)) pulse_viol++;
      if ((32'(rx_done_tick) + 32'(parity_err) + 32'(frame_err)) > 1) pulse_viol++;
      prev_any = rx_done_tick | parity_err | frame_err;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    @(negedge clk);
    ps2d = b;
    repeat (25) @(negedge clk);
    ps2c = 1'b0;
    repeat (50) @(negedge clk);
    ps2c = 1'b1;
    if (glitch) begin
      repeat (8) @(negedge clk);
      ps2c = 1'b0;
      repeat (3) @(negedge clk);
      ps2c = 1'b1;
      repeat (14) @(negedge clk);
    end else begin
      repeat (25) @(negedge clk);
    end
  endtask

  // Sends the first nbits bits of a frame; glitch_bit selects a bit with a short ps2c low pulse.
  task automatic send_frame(input logic [7:0] data, input bit flip_par, input logic stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] fr;
    fr = {stop, (~^data) ^ flip_par, data, 1'b0};
    for (int i = 0; i < nbits; i++) drive_bit(fr[i], i == glitch_bit);
    ps2d = 1'b1;
    if (nbits == 11) repeat (30) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; rx_en = 1'b1; ps2c = 1'b1; ps2d = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_dout", 32'(dout), 32'h00);
    chk("reset_tick", 32'(rx_done_tick), 32'h0);
    chk("reset_perr", 32'(parity_err), 32'h0);
    chk("reset_ferr", 32'(frame_err), 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single;
    int d0, p0, f0;
    d0 = cnt_done; p0 = cnt_perr; f0 = cnt_ferr;
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    chk("single_ticks", 32'(cnt_done - d0), 32'd1);
    chk("single_dout", 32'(dout), 32'h1C);
    chk("single_perr", 32'(cnt_perr - p0), 32'd0);
    chk("single_ferr", 32'(cnt_ferr - f0), 32'd0);
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = cnt_done;
    rx_q.delete();
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
    chk("b2b_first_dout", 32'(dout), 32'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    chk("b2b_ticks", 32'(cnt_done - d0), 32'd2);
    chk("b2b_qlen", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      chk("b2b_order0", 32'(rx_q[0]), 32'hF0);
      chk("b2b_order1", 32'(rx_q[1]), 32'h1C);
    end
  endtask

  task automatic test_parity;
    int d0, p0, f0;
    d0 = cnt_done; p0 = cnt_perr; f0 = cnt_ferr;
    send_frame(8'hA5, 1'b1, 1'b1, 11, -1);
    chk("par_perr", 32'(cnt_perr - p0), 32'd1);
    chk("par_ticks", 32'(cnt_done - d0), 32'd0);
    chk("par_ferr", 32'(cnt_ferr - f0), 32'd0);
    chk("par_dout_held", 32'(dout), 32'h1C);
  endtask

  task automatic test_frame_err;
    int d0, p0, f0;
    d0 = cnt_done; p0 = cnt_perr; f0 = cnt_ferr;
    // Bad stop and bad parity together: stop error wins.
    send_frame(8'h55, 1'b1, 1'b0, 11, -1);
    chk("stop_ferr", 32'(cnt_ferr - f0), 32'd1);
    chk("stop_perr", 32'(cnt_perr - p0), 32'd0);
    chk("stop_ticks", 32'(cnt_done - d0), 32'd0);
    chk("stop_dout_held", 32'(dout), 32'h1C);
    f0 = cnt_ferr;
    send_frame(8'h6B, 1'b0, 1'b1, 5, -1);
    repeat (TO_CYC - 250) @(negedge clk);
    chk("to_not_early", 32'(cnt_ferr - f0), 32'd0);
    repeat (500) @(negedge clk);
    chk("to_ferr", 32'(cnt_ferr - f0), 32'd1);
    chk("to_dout_held", 32'(dout), 32'h1C);
    d0 = cnt_done;
    send_frame(8'h32, 1'b0, 1'b1, 11, -1);
    chk("after_to_tick", 32'(cnt_done - d0), 32'd1);
    chk("after_to_dout", 32'(dout), 32'h32);
  endtask

  task automatic test_glitch_and_enable;
    int d0, p0, f0;
    d0 = cnt_done; p0 = cnt_perr; f0 = cnt_ferr;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); ps2d = 1'b0; ps2c = 1'b0;
      repeat (3) @(negedge clk); ps2c = 1'b1;
      repeat (40) @(negedge clk);
    end
    ps2d = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 3);
    chk("glitch_ticks", 32'(cnt_done - d0), 32'd1);
    chk("glitch_dout", 32'(dout), 32'h1C);
    chk("glitch_errs", 32'((cnt_perr - p0) + (cnt_ferr - f0)), 32'd0);
    d0 = cnt_done; p0 = cnt_perr; f0 = cnt_ferr;
    rx_en = 1'b0;
    send_frame(8'h45, 1'b0, 1'b1, 11, -1);
    repeat (TO_CYC + 100) @(negedge clk);
    rx_en = 1'b1;
    chk("rxen_pulses", 32'((cnt_done - d0) + (cnt_perr - p0) + (cnt_ferr - f0)), 32'd0);
    chk("rxen_dout", 32'(dout), 32'h1C);
  endtask

  task automatic test_reset_mid;
    int d0, p0, f0;
    d0 = cnt_done; p0 = cnt_perr; f0 = cnt_ferr;
    send_frame(8'h45, 1'b0, 1'b1, 6, -1);
    reset = 1'b1;
    #1;
    chk("rst_mid_dout", 32'(dout), 32'h00);
    chk("rst_mid_tick", 32'(rx_done_tick), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (TO_CYC + 100) @(negedge clk);
    chk("rst_mid_pulses", 32'((cnt_done - d0) + (cnt_perr - p0) + (cnt_ferr - f0)), 32'd0);
    d0 = cnt_done;
    send_frame(8'h45, 1'b0, 1'b1, 11, -1);
    chk("rst_next_tick", 32'(cnt_done - d0), 32'd1);
    chk("rst_next_dout", 32'(dout), 32'h45);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_glitch_and_enable();
    test_reset_mid();
    chk("pulse_rules", 32'(pulse_viol), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
